// File: rtl/topic_prob_gen.sv
// LDA topic weight generator: streams per-topic counts through a 2-stage Q16.16
// multiply pipeline into packed sampler slots, with per-layer LFSR random words.

module topic_prob_lfsr #(
    parameter logic [31:0] LANE_SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= LANE_SEED;
        else if (en) q <= {1'b0, q[31:1]} ^ (q[0] ? 32'h8020_0003 : 32'h0);
    end
endmodule

module topic_prob_gen #(
    parameter int          NUM_TOPICS     = 16,
    parameter int          NUM_TOPICS_LOG = 4,
    parameter logic [31:0] SEED           = 32'hACE1_0001
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_go,
    input  logic [31:0]                  i_ntopic,
    input  logic [31:0]                  i_alpha,
    input  logic [31:0]                  i_beta,
    input  logic                         i_cnt_valid,
    output logic                         o_cnt_ready,
    input  logic [15:0]                  i_ndk,
    input  logic [15:0]                  i_nwk,
    input  logic [31:0]                  i_inv_nk,
    output logic [NUM_TOPICS*32-1:0]     o_probs,
    output logic [NUM_TOPICS*32-1:0]     o_topics,
    output logic [NUM_TOPICS-1:0]        o_valid,
    output logic [NUM_TOPICS_LOG*32-1:0] o_random,
    output logic [31:0]                  o_ntopic,
    output logic                         o_start,
    input  logic                         i_done,
    output logic                         o_busy
);
    localparam int IW = NUM_TOPICS_LOG;
    localparam int CW = NUM_TOPICS_LOG + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, ISSUE} state_t;

    state_t                          state;
    logic [CW-1:0]                   ntop, cnt;
    logic [31:0]                     alpha, beta;
    logic [NUM_TOPICS-1:0][31:0]     probs_q, topics_q;
    logic [NUM_TOPICS_LOG-1:0][31:0] rnd;

    logic        fire;
    logic [2:1]  vld_pipe;
    logic [31:0] nt_clamp;
    logic [32:0] a, b;
    logic [65:0] prod1;
    logic [63:0] prod2;
    logic [31:0] m_sat, p_sat;
    logic [31:0] s1_m, s1_inv, s2_p;
    logic [IW-1:0] s1_idx, s2_idx;

    assign fire     = i_cnt_valid & o_cnt_ready;
    assign nt_clamp = (i_ntopic > 32'(NUM_TOPICS)) ? 32'(NUM_TOPICS) : i_ntopic;
    assign o_busy   = (state != IDLE);
    assign o_probs  = probs_q;
    assign o_topics = topics_q;
    assign o_random = rnd;

    // Products are computed at full width so saturation sees every overflow bit.
    assign a     = {1'b0, i_ndk, 16'b0} + {1'b0, alpha};
    assign b     = {1'b0, i_nwk, 16'b0} + {1'b0, beta};
    assign prod1 = {33'b0, a} * {33'b0, b};
    assign m_sat = (|prod1[65:48]) ? 32'hFFFF_FFFF : prod1[47:16];
    assign prod2 = {32'b0, s1_m} * {32'b0, s1_inv};
    assign p_sat = (|prod2[63:48]) ? 32'hFFFF_FFFF : prod2[47:16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_m     <= '0;
            s1_inv   <= '0;
            s1_idx   <= '0;
            s2_p     <= '0;
            s2_idx   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], fire};
            if (fire) begin
                s1_m   <= m_sat;
                s1_inv <= i_inv_nk;
                s1_idx <= cnt[IW-1:0];
            end
            if (vld_pipe[1]) begin
                s2_p   <= p_sat;
                s2_idx <= s1_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ntop        <= '0;
            cnt         <= '0;
            alpha       <= '0;
            beta        <= '0;
            o_ntopic    <= '0;
            o_cnt_ready <= 1'b0;
            o_start     <= 1'b0;
            o_valid     <= '0;
            probs_q     <= '0;
            topics_q    <= '0;
        end else begin
            case (state)
                IDLE: if (i_go) begin
                    o_ntopic <= nt_clamp;
                    ntop     <= nt_clamp[CW-1:0];
                    alpha    <= i_alpha;
                    beta     <= i_beta;
                    cnt      <= '0;
                    o_valid  <= '0;
                    probs_q  <= '0;
                    topics_q <= '0;
                    if (nt_clamp != 32'd0) begin
                        state       <= LOAD;
                        o_cnt_ready <= 1'b1;
                    end
                end
                LOAD: if (fire) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ntop - 1'b1) begin
                        o_cnt_ready <= 1'b0;
                        state       <= DRAIN;
                    end
                end
                // Stage 2 commits its slot on the same edge that raises o_start.
                DRAIN: if (!vld_pipe[1]) begin
                    state   <= ISSUE;
                    o_start <= 1'b1;
                end
                ISSUE: if (i_done) begin
                    o_start <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (vld_pipe[2]) begin
                probs_q[s2_idx]  <= s2_p;
                topics_q[s2_idx] <= 32'(s2_idx);
                o_valid[s2_idx]  <= 1'b1;
            end
        end
    end

    // Random words stay frozen while the sampler consumes them.
    genvar j;
    generate
        for (j = 0; j < NUM_TOPICS_LOG; j++) begin : g_lane
            localparam logic [31:0] RAW   = SEED ^ (32'(j) * 32'h9E37_79B9);
            localparam logic [31:0] LSEED = (RAW == 32'h0) ? 32'h1 : RAW;
            topic_prob_lfsr #(.LANE_SEED(LSEED)) u_lfsr (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (state != ISSUE),
                .q     (rnd[j])
            );
        end
    endgenerate
endmodule

// File: tb/tb_topic_prob_gen.sv
// Directed bench for topic_prob_gen: weights, handshake timing, clamping,
// saturation, back-pressure, mid-word reset and LFSR behaviour.

module tb_topic_prob_gen;
    localparam int NT = 16;
    localparam int NL = 4;
    localparam logic [NL*32-1:0] SEEDS =
        {32'h7647_6D2A, 32'h908F_F373, 32'h32D6_79B8, 32'hACE1_0001};
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic clk = 0, rst_n = 0;
    logic i_go = 0, i_cnt_valid = 0, i_done = 0;
    logic [31:0] i_ntopic = 0, i_alpha = 0, i_beta = 0, i_inv_nk = 0;
    logic [15:0] i_ndk = 0, i_nwk = 0;
    logic o_cnt_ready, o_start, o_busy;
    logic [NT*32-1:0] o_probs, o_topics;
    logic [NT-1:0] o_valid;
    logic [NL*32-1:0] o_random;
    logic [31:0] o_ntopic;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    topic_prob_gen dut (
        .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_ntopic(i_ntopic),
        .i_alpha(i_alpha), .i_beta(i_beta), .i_cnt_valid(i_cnt_valid),
        .o_cnt_ready(o_cnt_ready), .i_ndk(i_ndk), .i_nwk(i_nwk),
        .i_inv_nk(i_inv_nk), .o_probs(o_probs), .o_topics(o_topics),
        .o_valid(o_valid), .o_random(o_random), .o_ntopic(o_ntopic),
        .o_start(o_start), .i_done(i_done), .o_busy(o_busy)
    );

    function automatic logic [31:0] step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic go(input logic [31:0] nt, input logic [31:0] al, input logic [31:0] be);
        @(negedge clk);
        i_go = 1; i_ntopic = nt; i_alpha = al; i_beta = be;
        @(negedge clk);
        i_go = 0;
    endtask

    task automatic feed(input logic [15:0] ndk, input logic [15:0] nwk, input logic [31:0] inv);
        i_cnt_valid = 1; i_ndk = ndk; i_nwk = nwk; i_inv_nk = inv;
        for (int n = 0; n < 20; n++) begin
            if (o_cnt_ready) begin @(negedge clk); return; end
            @(negedge clk);
        end
        total++; bad++;
        $display("FAIL feed_timeout: ready never seen, want ready=1");
    endtask

    task automatic wait_start();
        for (int n = 0; n < 50; n++) begin
            if (o_start) return;
            @(negedge clk);
        end
        total++; bad++;
        $display("FAIL start_timeout: o_start=0, want 1");
    endtask

    task automatic finish_word();
        i_done = 1;
        @(negedge clk);
        i_done = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({o_start, o_busy, o_cnt_ready, o_valid, o_ntopic} !== '0 || o_probs !== '0 || o_topics !== '0) begin
            bad++; $display("FAIL reset_outputs: start=%b busy=%b valid=%h ntopic=%h, want all 0",
                            o_start, o_busy, o_valid, o_ntopic);
        end
        total++;
        if (o_random !== SEEDS) begin
            bad++; $display("FAIL reset_seeds: got %h want %h", o_random, SEEDS);
        end
        rst_n = 1;
        @(negedge clk);
        total++;
        if (o_random[31:0] !== 32'hD650_8003) begin
            bad++; $display("FAIL lfsr_first_step: got %h want D6508003", o_random[31:0]);
        end
    endtask

    task automatic test_single();
        go(1, ONE, ONE);
        feed(16'd1, 16'd1, 32'h0000_8000);
        i_cnt_valid = 0;
        total++;
        if (o_cnt_ready !== 1'b0 || o_start !== 1'b0) begin
            bad++; $display("FAIL single_after_beat: ready=%b start=%b want 0 0", o_cnt_ready, o_start);
        end
        @(negedge clk);
        total++;
        if (o_start !== 1'b0) begin
            bad++; $display("FAIL single_start_early: start=%b want 0", o_start);
        end
        @(negedge clk);
        total++;
        if (o_start !== 1'b1 || o_busy !== 1'b1) begin
            bad++; $display("FAIL single_start_timing: start=%b busy=%b want 1 1", o_start, o_busy);
        end
        total++;
        if (o_probs[31:0] !== 32'h0002_0000 || o_valid !== 16'h0001) begin
            bad++; $display("FAIL single_slot: prob=%h valid=%h want 00020000 0001", o_probs[31:0], o_valid);
        end
        finish_word();
        total++;
        if (o_start !== 1'b0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL single_done: start=%b busy=%b want 0 0", o_start, o_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [NL*32-1:0] r;
        go(16, ONE, ONE);
        for (int k = 0; k < 16; k++) feed(16'(k), 16'd0, ONE);
        i_cnt_valid = 0;
        total++;
        if (o_cnt_ready !== 1'b0) begin
            bad++; $display("FAIL full_ready_low: ready=%b want 0", o_cnt_ready);
        end
        wait_start();
        for (int k = 0; k < 16; k++) begin
            total++;
            if (o_probs[32*k +: 32] !== 32'((k + 1) << 16) || o_topics[32*k +: 32] !== 32'(k)) begin
                bad++; $display("FAIL full_slot%0d: prob=%h topic=%h want %h %h", k,
                                o_probs[32*k +: 32], o_topics[32*k +: 32], 32'((k + 1) << 16), 32'(k));
            end
        end
        total++;
        if (o_valid !== 16'hFFFF || o_ntopic !== 32'd16) begin
            bad++; $display("FAIL full_valid: valid=%h ntopic=%h want FFFF 10", o_valid, o_ntopic);
        end
        r = o_random;
        repeat (3) @(negedge clk);
        total++;
        if (o_random !== r) begin
            bad++; $display("FAIL lfsr_frozen: got %h want %h", o_random, r);
        end
        finish_word();
    endtask

    task automatic test_clamp_zero();
        int acc = 0;
        go(40, ONE, ONE);
        total++;
        if (o_ntopic !== 32'd16) begin
            bad++; $display("FAIL clamp_ntopic: got %0d want 16", o_ntopic);
        end
        i_cnt_valid = 1; i_ndk = 0; i_nwk = 0; i_inv_nk = ONE;
        for (int n = 0; n < 22; n++) begin
            if (o_cnt_ready) acc++;
            @(negedge clk);
        end
        i_cnt_valid = 0;
        total++;
        if (acc != 16) begin
            bad++; $display("FAIL clamp_beats: got %0d want 16", acc);
        end
        wait_start();
        finish_word();
        go(0, ONE, ONE);
        acc = 0;
        for (int n = 0; n < 6; n++) begin
            if (o_busy || o_start) acc++;
            @(negedge clk);
        end
        total++;
        if (acc != 0 || o_valid !== '0) begin
            bad++; $display("FAIL zero_word: busy/start cycles=%0d valid=%h want 0 0", acc, o_valid);
        end
    endtask

    task automatic test_saturation();
        go(1, ONE, ONE);
        feed(16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF);
        i_cnt_valid = 0;
        wait_start();
        total++;
        if (o_probs[31:0] !== 32'hFFFF_FFFF || o_probs[63:32] !== 32'h0 || o_valid !== 16'h0001) begin
            bad++; $display("FAIL sat_slot: prob0=%h prob1=%h valid=%h want FFFFFFFF 0 0001",
                            o_probs[31:0], o_probs[63:32], o_valid);
        end
        finish_word();
    endtask

    task automatic test_backpressure();
        go(4, ONE, ONE);
        for (int k = 0; k < 4; k++) begin
            i_cnt_valid = 0; i_ndk = 16'hBEEF;
            @(negedge clk);
            feed(16'(k), 16'd0, ONE);
        end
        i_cnt_valid = 0;
        wait_start();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (o_probs[32*k +: 32] !== 32'((k + 1) << 16)) begin
                bad++; $display("FAIL bp_slot%0d: got %h want %h", k, o_probs[32*k +: 32], 32'((k + 1) << 16));
            end
        end
        total++;
        if (o_valid !== 16'h000F) begin
            bad++; $display("FAIL bp_valid: got %h want 000F", o_valid);
        end
        finish_word();
    endtask

    task automatic test_reset_mid();
        go(1, ONE, ONE);
        feed(16'd1, 16'd1, 32'h0000_8000);
        i_cnt_valid = 0;
        wait_start();
        rst_n = 0;
        #1;
        total++;
        if ({o_start, o_busy, o_cnt_ready, o_valid, o_ntopic} !== '0 || o_probs !== '0 || o_random !== SEEDS) begin
            bad++; $display("FAIL mid_reset: start=%b busy=%b valid=%h random=%h want 0 0 0 %h",
                            o_start, o_busy, o_valid, o_random, SEEDS);
        end
        @(negedge clk);
        rst_n = 1;
        go(1, ONE, ONE);
        feed(16'd2, 16'd0, ONE);
        i_cnt_valid = 0;
        wait_start();
        total++;
        if (o_probs[31:0] !== 32'h0003_0000 || o_valid !== 16'h0001) begin
            bad++; $display("FAIL post_reset_word: prob=%h valid=%h want 00030000 0001", o_probs[31:0], o_valid);
        end
        finish_word();
    endtask

    task automatic test_lfsr_idle();
        logic [NL*32-1:0] r, e;
        @(negedge clk);
        r = o_random;
        for (int j = 0; j < NL; j++) e[32*j +: 32] = step(r[32*j +: 32]);
        @(negedge clk);
        total++;
        if (o_random !== e) begin
            bad++; $display("FAIL lfsr_idle_step: got %h want %h", o_random, e);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_clamp_zero();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_lfsr_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/topic_prob_gen.md
Name: topic_prob_gen

Overview:
Upstream feeder for the tree sampler in the LDA Gibbs-sampling datapath.
- Accepts a stream of per-topic counts, one topic per beat.
- Computes the unnormalised weight p(k) = (n_dk+alpha)*(n_wk+beta)*inv_nk in Q16.16 through a 2-stage pipeline.
- Buffers the weights into the packed probability/topic/valid vectors the sampler consumes, supplies per-layer LFSR random words, and drives the sampler start pulse until the sampler reports done.

Parameters:
NUM_TOPICS, 16, number of topic slots; power of two.
NUM_TOPICS_LOG, 4, log2(NUM_TOPICS); number of random lanes.
SEED, 32'hACE1_0001, base LFSR seed.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_go  in  1  start a new word; sampled only in IDLE
i_ntopic  in  32  topics to load this word; latched on accepted i_go
i_alpha  in  32  Q16.16 alpha; latched on accepted i_go
i_beta  in  32  Q16.16 beta; latched on accepted i_go
i_cnt_valid  in  1  count beat valid
o_cnt_ready  out  1  count beat ready
i_ndk  in  16  document-topic count (integer)
i_nwk  in  16  word-topic count (integer)
i_inv_nk  in  32  Q16.16 reciprocal of (n_k + V*beta)
o_probs  out  NUM_TOPICS*32  packed weights; slot k at [32k+31:32k]
o_topics  out  NUM_TOPICS*32  packed topic ids; slot k holds k
o_valid  out  NUM_TOPICS  slot valid mask
o_random  out  NUM_TOPICS_LOG*32  packed LFSR words; lane j at [32j+31:32j]
o_ntopic  out  32  latched, clamped topic count
o_start  out  1  sampler start, level
i_done  in  1  sampler done
o_busy  out  1  high in any state except IDLE

Behaviour:
Reset values:
- All outputs 0, except o_random = lane seeds.
- State IDLE; load counter 0; pipeline empty.
- Reset mid-operation aborts everything, including a held o_start.

State machine: IDLE -> LOAD -> DRAIN -> ISSUE -> IDLE.
- IDLE -> LOAD on i_go.
  - Latch i_ntopic; clamp to NUM_TOPICS if larger.
  - Latch i_alpha and i_beta.
  - Clear o_valid and all slots.
  - If the clamped ntopic is 0, stay in IDLE with no start.
- LOAD: o_cnt_ready = 1 while accepted beats < ntopic.
  - A beat transfers when i_cnt_valid & o_cnt_ready.
  - Topic index = arrival order 0..ntopic-1.
  - After the ntopic-th transfer, go to DRAIN.
- DRAIN: wait until the pipeline is empty (at most 2 cycles), then go to ISSUE.
- ISSUE: o_start = 1, held.
  - On i_done, deassert o_start the next cycle and return to IDLE.
  - o_start is low for at least 1 cycle before any later assertion, because it is low throughout IDLE/LOAD.
- i_go outside IDLE is ignored.

Datapath:
- Stage 1 (registered):
  - a = {i_ndk,16'b0} + alpha and b = {i_nwk,16'b0} + beta, each 33-bit.
  - m = (a*b) >> 16, saturated to 32'hFFFF_FFFF if it exceeds 32 bits.
  - inv_nk and the topic index are registered alongside.
- Stage 2 (registered): p = (m*inv_nk) >> 16, saturated the same way; written to o_probs slot idx; o_valid[idx] = 1.
- Latency: beat accepted at cycle t -> slot written at the end of cycle t+2.
- Slots >= ntopic stay at prob 0, topic 0, valid 0.
- o_topics slot k = k for k < ntopic.

LFSR:
- One 32-bit Galois LFSR per lane j, taps 32'h80200003.
- Seed = SEED ^ (j*32'h9E3779B9); if the result is 0, use 1.
- Each lane advances one step per cycle in IDLE, LOAD and DRAIN.
- Lanes are frozen in ISSUE, so the sampler sees stable values.
- State is never 0.

Back-pressure: i_cnt_valid may drop mid-word; the load counter and pipeline hold with no bubble corruption.

Test Plan:
- alpha=beta=32'h0001_0000; ntopic=1; ndk=1, nwk=1, inv_nk=32'h0000_8000 -> o_probs slot0 = 32'h0002_0000, o_valid=16'h0001, o_start high 3 cycles after the beat; i_done -> o_start low next cycle, o_busy=0.
- ntopic=16, beats back-to-back, ndk=k, nwk=0, alpha=beta=1.0, inv_nk=1.0 -> slot k = (k+1)<<16, o_valid=16'hFFFF, o_ready low after 16th beat.
- ntopic=40 -> o_ntopic=16, exactly 16 beats accepted; ntopic=0 -> o_busy stays 0, no o_start.
- ndk=nwk=16'hFFFF, inv_nk=32'hFFFF_FFFF -> slot = 32'hFFFF_FFFF (saturation); i_cnt_valid toggling every other cycle with ntopic=4 -> identical slot values to the back-to-back case.
- rst_n low while o_start high in ISSUE -> all outputs 0, o_random back to seeds; the next i_go runs a clean word.
- o_random lanes constant throughout ISSUE, advancing in IDLE; lane0 after 1 step from 32'hACE1_0001 = 32'hD6508003.
